// File: rtl/packet_rr_arbiter_pkg.sv
// packet_rr_arbiter_pkg: shared FSM state encoding and index-width helper
// Exports: ST_IDLE/ST_LOCK state constants, clog2w(n) index width (minimum 1)
package packet_rr_arbiter_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/packet_out_slice.sv
// packet_out_slice: single output register stage with valid/ready backpressure
// Ports: clk, rst_n (sync, active-low); load/in_* = beat accepted this cycle;
//        in_ready = slot free or draining; out_* = registered beat to downstream
module packet_out_slice #(
  parameter int HW = 512,
  parameter int PW = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [HW-1:0] in_head,
  input  logic [PW-1:0] in_data,
  input  logic          in_start,
  input  logic          in_last,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic [HW-1:0] out_head,
  output logic [PW-1:0] out_data,
  output logic          out_start,
  output logic          out_last
);
  logic          valid_q, valid_d;
  logic [HW-1:0] head_q, head_d;
  logic [PW-1:0] data_q, data_d;
  logic          start_q, start_d;
  logic          last_q, last_d;
  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_head  = head_q;
  assign out_data  = data_q;
  assign out_start = start_q;
  assign out_last  = last_q;
  always_comb begin
    valid_d = load || (valid_q && !out_ready);
    head_d  = load ? in_head : head_q;
    data_d  = load ? in_data : data_q;
    start_d = load ? in_start : start_q;
    last_d  = load ? in_last : last_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      head_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      data_q  <= data_d;
      start_q <= start_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: rtl/packet_rr_arbiter.sv
// packet_rr_arbiter: round-robin packet merger locking the output per whole packet
// Ports: clk, rst_n (sync, active-low); per-port valid/head/data/start/last in,
//        per-port ready out; merged valid/head/data/start/last out with downstream
//        ready in; ov_grant_port = current owner; o_framing_err = sticky error
module packet_rr_arbiter
  import packet_rr_arbiter_pkg::*;
#(
  parameter int NUM_PORTS         = 4,
  parameter int HEADER_BUS_WIDTH  = 512,
  parameter int PAYLOAD_BUS_WIDTH = 512
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_PORTS-1:0]                   i_packet_in_valid,
  input  logic [NUM_PORTS*HEADER_BUS_WIDTH-1:0]  iv_packet_in_head,
  input  logic [NUM_PORTS*PAYLOAD_BUS_WIDTH-1:0] iv_packet_in_data,
  input  logic [NUM_PORTS-1:0]                   i_packet_in_start,
  input  logic [NUM_PORTS-1:0]                   i_packet_in_last,
  output logic [NUM_PORTS-1:0]                   o_packet_in_ready,
  output logic                                   o_packet_out_valid,
  output logic [HEADER_BUS_WIDTH-1:0]            ov_packet_out_head,
  output logic [PAYLOAD_BUS_WIDTH-1:0]           ov_packet_out_data,
  output logic                                   o_packet_out_start,
  output logic                                   o_packet_out_last,
  input  logic                                   i_packet_out_ready,
  output logic [clog2w(NUM_PORTS)-1:0]           ov_grant_port,
  output logic                                   o_framing_err
);
  localparam int GW = clog2w(NUM_PORTS);
  logic [0:0]                   state_q, state_d;
  logic [GW-1:0]                grant_q, grant_d;
  logic [GW-1:0]                last_grant_q, last_grant_d;
  logic                         first_q, first_d;
  logic                         err_q, err_d;
  logic [NUM_PORTS-1:0]         cand;
  logic [GW-1:0]                pick, idx;
  logic                         found, lock, slot_ready, accept;
  logic                         sel_valid, sel_start, sel_last;
  logic [HEADER_BUS_WIDTH-1:0]  sel_head;
  logic [PAYLOAD_BUS_WIDTH-1:0] sel_data;
  assign lock              = state_q == ST_LOCK;
  assign sel_valid         = i_packet_in_valid[grant_q];
  assign sel_start         = i_packet_in_start[grant_q];
  assign sel_last          = i_packet_in_last[grant_q];
  assign sel_head          = iv_packet_in_head[int'(grant_q)*HEADER_BUS_WIDTH +: HEADER_BUS_WIDTH];
  assign sel_data          = iv_packet_in_data[int'(grant_q)*PAYLOAD_BUS_WIDTH +: PAYLOAD_BUS_WIDTH];
  assign accept            = lock && sel_valid && slot_ready;
  assign o_packet_in_ready = (lock && slot_ready) ? NUM_PORTS'(1) << grant_q : '0;
  assign ov_grant_port     = grant_q;
  assign o_framing_err     = err_q;
  // Scan ports starting one past the last owner; first packet-start wins.
  always_comb begin
    cand  = i_packet_in_valid & i_packet_in_start;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = GW'((int'(last_grant_q) + i) % NUM_PORTS);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end
  // first_q marks that the next accepted beat is the packet's opening beat,
  // so a start flag seen on any later beat is a framing error.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    first_d      = first_q;
    err_d        = err_q || (!lock && |(i_packet_in_valid & ~i_packet_in_start))
                         || (accept && sel_start && !first_q);
    if (!lock && found) begin
      state_d = ST_LOCK;
      grant_d = pick;
      first_d = 1'b1;
    end
    if (accept) begin
      first_d = 1'b0;
      if (sel_last) begin
        state_d      = ST_IDLE;
        last_grant_d = grant_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_PORTS - 1);
      first_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      first_q      <= first_d;
      err_q        <= err_d;
    end
  end
  packet_out_slice #(
    .HW(HEADER_BUS_WIDTH),
    .PW(PAYLOAD_BUS_WIDTH)
  ) u_slice (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .in_head  (sel_head),
    .in_data  (sel_data),
    .in_start (sel_start),
    .in_last  (sel_last),
    .out_ready(i_packet_out_ready),
    .in_ready (slot_ready),
    .out_valid(o_packet_out_valid),
    .out_head (ov_packet_out_head),
    .out_data (ov_packet_out_data),
    .out_start(o_packet_out_start),
    .out_last (o_packet_out_last)
  );
endmodule

// File: doc/packet_rr_arbiter.md
PACKET_RR_ARBITER -- requirements
Module: packet_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of packet requesters (2..8).
REQ-002 SHALL have parameter HEADER_BUS_WIDTH, default 512, head bus width per port.
REQ-003 SHALL have parameter PAYLOAD_BUS_WIDTH, default 512, data bus width per port.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_packet_in_valid  in  NUM_PORTS  per-port beat valid.
REQ-007 SHALL have port iv_packet_in_head  in  NUM_PORTS*HEADER_BUS_WIDTH  per-port head; port p at slice p.
REQ-008 SHALL have port iv_packet_in_data  in  NUM_PORTS*PAYLOAD_BUS_WIDTH  per-port data; port p at slice p.
REQ-009 SHALL have port i_packet_in_start  in  NUM_PORTS  per-port first-beat flag.
REQ-010 SHALL have port i_packet_in_last  in  NUM_PORTS  per-port last-beat flag.
REQ-011 SHALL have port o_packet_in_ready  out  NUM_PORTS  per-port ready.
REQ-012 SHALL have port o_packet_out_valid  out  1  merged stream valid.
REQ-013 SHALL have port ov_packet_out_head  out  HEADER_BUS_WIDTH  merged head.
REQ-014 SHALL have port ov_packet_out_data  out  PAYLOAD_BUS_WIDTH  merged data.
REQ-015 SHALL have port o_packet_out_start / o_packet_out_last  out  1 each  merged framing.
REQ-016 SHALL have port i_packet_out_ready  in  1  downstream ready.
REQ-017 SHALL have port ov_grant_port  out  clog2(NUM_PORTS)  port currently owning the output.
REQ-018 SHALL have port o_framing_err  out  1  sticky framing-error flag.

Function
REQ-019 SHALL implement states IDLE and LOCK.
REQ-020 In IDLE, candidates SHALL be ports with valid=1 and start=1; if any, one is chosen round-robin starting at (last_grant+1) mod NUM_PORTS, latched into ov_grant_port, and state goes to LOCK next cycle.
REQ-021 In IDLE, all o_packet_in_ready bits SHALL be 0.
REQ-022 In LOCK, o_packet_in_ready[g] SHALL be (!o_packet_out_valid || i_packet_out_ready) for granted g, 0 for every other port.
REQ-023 A beat SHALL transfer on valid&ready of the granted port into a single output register stage; latency input-handshake to output valid = 1 cycle; throughput one beat/cycle under continuous ready.
REQ-024 Output register SHALL hold head/data/start/last stable while o_packet_out_valid=1 and i_packet_out_ready=0.
REQ-025 Output valid SHALL clear on downstream handshake when no new beat is accepted in the same cycle.
REQ-026 Accepting a beat with last=1 (including start&last single-beat packets) SHALL return state to IDLE next cycle; last_grant := g.
REQ-027 Grant SHALL never change mid-packet, regardless of other ports' requests.
REQ-028 A beat accepted in LOCK with start=1 other than the first beat of the packet SHALL set o_framing_err; the beat is still forwarded.
REQ-029 In IDLE, a port with valid=1 and start=0 SHALL not be granted and SHALL set o_framing_err.
REQ-030 o_framing_err SHALL stay set until reset.
REQ-031 Simultaneous multiple candidates SHALL be resolved solely by round-robin pointer; no port starves beyond NUM_PORTS-1 packets.

Reset
REQ-032 On rst_n=0 at a clock edge: state=IDLE, o_packet_out_valid=0, head/data/start/last outputs=0, ov_grant_port=0, last_grant=NUM_PORTS-1, o_framing_err=0, o_packet_in_ready=0.
REQ-033 Reset mid-packet SHALL discard the in-flight packet and output beat without completing it.

Structure
REQ-034 State encoding and clog2 width helper SHALL reside in the shared common function/definition include.
REQ-035 Output register stage SHALL be one sub-module, packet_out_slice; the round-robin pick is inline.

Verification
REQ-036 Port 1 alone sends 3-beat packet, ready=1 -> out beats 1 cycle after each accept, start on beat 1, last on beat 3, ov_grant_port=1.
REQ-037 Ports 0,2,3 all request in IDLE after reset -> grant order 0,2,3 with whole packets contiguous, no interleave.
REQ-038 i_packet_out_ready held 0 for 5 cycles mid-packet -> output beat stable, granted ready=0, no data loss.
REQ-039 Port 2 sends valid with start=0 in IDLE -> never granted, o_framing_err=1 next cycle and sticky.
REQ-040 Back-to-back single-beat packets (start=last=1) on ports 0 and 1 -> alternate grant 0,1,0,1, one IDLE cycle between packets.
REQ-041 rst_n=0 on beat 2 of a 4-beat packet -> all outputs return to reset values next cycle; next packet arbitrates from port 0.
